// File: rtl/noc_ni_local_pkg.sv
// Shared flit layout, FSM state types and parity helpers
// for the local-port network interface.
package noc_ni_local_pkg;

  localparam int FLIT_W   = 32;
  localparam int PAY_W    = 28;
  localparam int LEN_W    = 12;
  localparam int ADDR_W   = 4;

  localparam int TYPE_LSB = 29;
  localparam int LEN_LSB  = 17;
  localparam int DST_LSB  = 13;
  localparam int SRC_LSB  = 9;

  localparam logic [2:0] FT_HEADER = 3'b001;
  localparam logic [2:0] FT_BODY   = 3'b010;
  localparam logic [2:0] FT_TAIL   = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    PAY
  } tx_state_e;

  typedef enum logic {
    R_HDR,
    R_PAY
  } rx_state_e;

  function automatic logic [FLIT_W-1:0] mk_flit(
    input logic [2:0]       ft,
    input logic [PAY_W-1:0] body
  );
    return {ft, body, ^{ft, body}};
  endfunction

  function automatic logic parity_ok(
    input logic [FLIT_W-1:0] f
  );
    return (^f[FLIT_W-1:1]) == f[0];
  endfunction

endpackage

// File: rtl/noc_ni_local_rx_fifo.sv
// Receive flit FIFO: occupancy count, full/empty,
// writes while full are silently dropped.
module ni_rx_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   count_q;
  logic          wr_ok, rd_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rp_q];
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wp_q <= wp_q + 1'b1;
      if (rd_ok) rp_q <= rp_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= wr_data_i;
  end

endmodule

// File: rtl/noc_ni_local.sv
// Local-port NI: packetizes PE requests toward the router
// and de-packetizes router flits back to the PE.
module noc_ni_local
  import noc_ni_local_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] CUR_ADDR   = 4'b0011,
  parameter int         RX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] TX,
  output logic                  RTS,
  input  logic                  DCTS,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  pe_req,
  input  logic [3:0]            pe_dst,
  input  logic [11:0]           pe_len,
  output logic                  pe_ack,
  input  logic                  pe_wvalid,
  input  logic [27:0]           pe_wdata,
  output logic                  pe_wready,
  output logic                  rx_valid,
  output logic [27:0]           rx_data,
  output logic [3:0]            rx_src,
  output logic                  rx_last,
  input  logic                  rx_ready,
  output logic                  err_parity,
  output logic                  err_ovf,
  output logic                  err_len
);

  localparam int CW = $clog2(RX_DEPTH) + 1;

  tx_state_e        tx_q, tx_d;
  logic [3:0]       dst_q, dst_d;
  logic [11:0]      len_q, len_d;
  logic [11:0]      cnt_q, cnt_d;
  logic [31:0]      last_q;
  logic [31:0]      tx_flit;
  logic             req_ok, is_tail, pay_xfer;

  rx_state_e        rx_q, rx_d;
  logic [3:0]       src_q, src_d;
  logic [11:0]      rem_q, rem_d;
  logic             rx_pop, len_bad;
  logic [31:0]      head;
  logic [2:0]       head_t;
  logic [CW-1:0]    rx_cnt;
  logic             fifo_full, fifo_empty;
  logic             errp_q, erro_q, errl_q;

  assign req_ok   = pe_req && (pe_len != '0);
  assign is_tail  = (cnt_q == len_q - 12'd1);
  assign pay_xfer = (tx_q == PAY) && pe_wvalid && DCTS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= IDLE;
      dst_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      tx_q  <= tx_d;
      dst_q <= dst_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      if (RTS) last_q <= tx_flit;
    end
  end

  always_comb begin
    tx_d  = tx_q;
    dst_d = dst_q;
    len_d = len_q;
    cnt_d = cnt_q;
    unique case (tx_q)
      IDLE: if (req_ok) begin
        tx_d  = HEAD;
        dst_d = pe_dst;
        len_d = pe_len;
      end
      HEAD: if (DCTS) begin
        tx_d  = PAY;
        cnt_d = '0;
      end
      PAY: if (pay_xfer) begin
        cnt_d = cnt_q + 12'd1;
        if (is_tail) tx_d = IDLE;
      end
      default: tx_d = IDLE;
    endcase
  end

  // Ack is gated by rst so it stays low for the whole reset window.
  always_comb begin
    pe_ack    = 1'b0;
    RTS       = 1'b0;
    pe_wready = 1'b0;
    tx_flit   = last_q;
    unique case (tx_q)
      IDLE: pe_ack = req_ok && !rst;
      HEAD: begin
        RTS     = DCTS;
        tx_flit = mk_flit(FT_HEADER,
          {len_q + 12'd1, dst_q, CUR_ADDR, 8'h00});
      end
      PAY: begin
        pe_wready = DCTS;
        RTS       = pay_xfer;
        tx_flit   = mk_flit(is_tail ? FT_TAIL : FT_BODY,
          pe_wdata);
      end
      default: ;
    endcase
  end

  assign TX = RTS ? tx_flit : last_q;

  ni_rx_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (DRTS),
    .wr_data_i (RX),
    .rd_en_i   (rx_pop),
    .rd_data_o (head),
    .count_o   (rx_cnt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Router output lags DCTS by a register, so keep one slot spare.
  assign CTS    = (rx_cnt <= CW'(RX_DEPTH - 2));
  assign head_t = head[31:TYPE_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q   <= R_HDR;
      src_q  <= '0;
      rem_q  <= '0;
      errp_q <= 1'b0;
      erro_q <= 1'b0;
      errl_q <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      src_q  <= src_d;
      rem_q  <= rem_d;
      errp_q <= errp_q | (rx_pop && !parity_ok(head));
      erro_q <= erro_q | (DRTS && fifo_full);
      errl_q <= errl_q | len_bad;
    end
  end

  always_comb begin
    rx_d    = rx_q;
    src_d   = src_q;
    rem_d   = rem_q;
    rx_pop  = 1'b0;
    len_bad = 1'b0;
    unique case (rx_q)
      R_HDR: if (!fifo_empty) begin
        rx_pop = 1'b1;
        if (head_t == FT_HEADER) begin
          src_d = head[SRC_LSB +: 4];
          rem_d = head[LEN_LSB +: 12] - 12'd1;
          rx_d  = R_PAY;
        end else begin
          len_bad = 1'b1;
        end
      end
      R_PAY: if (!fifo_empty && rx_ready) begin
        rx_pop = 1'b1;
        rem_d  = rem_q - 12'd1;
        if (head_t == FT_TAIL) begin
          len_bad = (rem_q != 12'd1);
          rx_d    = R_HDR;
        end else begin
          len_bad = (rem_q == 12'd1);
        end
      end
    endcase
  end

  assign rx_valid   = (rx_q == R_PAY) && !fifo_empty;
  assign rx_data    = (rx_q == R_PAY) ? head[28:1] : '0;
  assign rx_last    = (rx_q == R_PAY) && (head_t == FT_TAIL);
  assign rx_src     = src_q;
  assign err_parity = errp_q;
  assign err_ovf    = erro_q;
  assign err_len    = errl_q;

endmodule

// File: doc/noc_ni_local.md
Name: noc_ni_local

Overview:
- Network interface attached to a router's Local port; sits directly upstream (TX) and downstream (RX) of the router's L port.
- TX path packetizes PE requests into header/body/tail flits and drives the router's L_RX/L_DRTS under L_CTS flow control.
- RX path accepts flits from the router's L_TX/L_RTS, buffers them, strips the header and delivers payload words to the PE.
- RX path drives L_DCTS.

Parameters:
- DATA_WIDTH, 32, flit width; fixed at 32 (field map below assumes it).
- CUR_ADDR, 4'b0011, this node's address; inserted as source field.
- RX_DEPTH, 4, receive FIFO depth in flits; power of 2, minimum 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- TX  out  32  flit to router L_RX
- RTS  out  1  flit-valid strobe to router L_DRTS
- DCTS  in  1  router L_CTS (router input FIFO not full)
- RX  in  32  flit from router L_TX
- DRTS  in  1  router L_RTS (flit present on RX this cycle)
- CTS  out  1  to router L_DCTS (NI can accept a flit)
- pe_req  in  1  PE requests a new packet
- pe_dst  in  4  destination address
- pe_len  in  12  payload flit count, 1..4094
- pe_ack  out  1  one-cycle pulse: request accepted
- pe_wvalid  in  1  payload word valid
- pe_wdata  in  28  payload word
- pe_wready  out  1  payload word accepted this cycle
- rx_valid  out  1  payload word available
- rx_data  out  28  payload word
- rx_src  out  4  source address of current packet
- rx_last  out  1  current word is the tail
- rx_ready  in  1  PE consumes word
- err_parity  out  1  sticky: parity mismatch seen
- err_ovf  out  1  sticky: flit arrived while RX FIFO full (flit dropped)
- err_len  out  1  sticky: tail position disagreed with header length

Behaviour:
Flit format:
- [31:29] type: 001 header, 010 body, 100 tail.
- [0] even parity: bit0 = ^flit[31:1].
- Header: [28:17] length = pe_len+1 (total flits); [16:13] dst; [12:9] src = CUR_ADDR; [8:1] zero.
- Body/tail: [28:1] payload.

Reset:
- All outputs 0; FSMs to IDLE; FIFO empty; sticky errors cleared.
- Exceptions: CTS is combinational and reads 1 once the FIFO is empty; pe_ack stays 0.
- Mid-packet reset abandons the packet; no tail is sent.

TX FSM (IDLE, HEAD, PAY):
- IDLE: pe_req && pe_len!=0 -> latch dst/len, pe_ack=1 for one cycle, go to HEAD.
- IDLE: pe_req with pe_len==0 -> ignored, no ack.
- HEAD: TX=header; RTS = DCTS (combinational); on DCTS go to PAY with cnt=0.
- PAY: pe_wready = DCTS; transfer when pe_wvalid && DCTS; RTS = that condition; TX = {type,pe_wdata,parity}.
- PAY: type is tail when cnt==len-1, else body; cnt increments per transfer; tail -> IDLE.
- RTS is never asserted while DCTS=0. TX holds its last value when RTS=0.
- Minimum latency: header leaves the cycle after pe_ack. One flit per cycle while DCTS=1.

RX buffering:
- Flit written to FIFO when DRTS=1.
- Router output is registered one cycle after DCTS is sampled, so CTS = (count <= RX_DEPTH-2).
- DRTS with FIFO full -> drop flit, set err_ovf.
- Simultaneous write and read: count unchanged. Pointers wrap modulo RX_DEPTH.

RX FSM (R_HDR, R_PAY):
- R_HDR: head of FIFO popped internally, never presented to the PE; latch src and length-1 into remaining.
- R_HDR: non-header type -> pop/discard, set err_len.
- R_PAY: rx_valid = !empty; rx_data = flit[28:1]; rx_last = (type==tail).
- R_PAY: pop on rx_valid && rx_ready; remaining decrements.
- Tail with remaining!=1, or body with remaining==1 -> set err_len; tail always returns to R_HDR.
- Parity checked on every popped flit; mismatch sets err_parity, but the flit is still delivered.

Decomposition:
- Shared package/include: flit type codes (HEADER/BODY/TAIL), field offsets (TYPE_LSB=29, LEN_LSB=17, DST_LSB=13, SRC_LSB=9), parity helper function.
- One sub-module: ni_rx_fifo (synchronous FIFO with count, full/empty, write-drop on full).
- TX and RX FSMs stay in the top module.

Test Plan:
- pe_req dst=4'b0000, pe_len=2, words 28'hABCDEF1, 28'h1234567, DCTS=1 -> pe_ack pulse, then 3 consecutive RTS cycles.
  - TX[31:29]=001, [28:17]=3, [16:13]=0, [12:9]=3; then body, then tail; each bit0 = even parity.
- Same packet with DCTS low for 3 cycles mid-packet -> RTS and pe_wready held 0 during stall; flit order and count unchanged.
- Inject header (len=3,src=1) plus 2 flits via DRTS with rx_ready=1 -> rx_valid twice, rx_src=1, rx_last on the second word; no error flags.
- rx_ready=0, DRTS every cycle -> CTS drops when count reaches RX_DEPTH-1 (3).
  - Then a flit with FIFO full is dropped and err_ovf=1.
- Header len=4 followed by a tail after 1 body -> err_len=1; next header is parsed normally.
- Flip bit 5 of an injected body flit -> err_parity=1, word still delivered.
- Assert rst mid-packet -> RTS=0, pe_ack=0, error flags cleared immediately (asynchronous).
  - After release, TX FSM is in IDLE and a new request is accepted.
